spi_master_ctrl: RTL and testbench

SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

---
 rtl/spi_master_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_spi_master_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/spi_master_ctrl.sv
// SPI master: one request in, one response out, per-transaction slave select.
// Build option SPI_MASTER_CTRL_LSB_FIRST_EN selects LSB-first shifting (default MSB-first).
module spi_master_ctrl #(
  parameter int DIV = 2,
  parameter int NSS = 8
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [6:0]     req_len,
  input  logic [2:0]     req_sel,
  input  logic [63:0]    req_wdata,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [63:0]    rsp_rdata,
  output logic           sck,
  output logic [NSS-1:0] ss,
  output logic           mosi,
  input  logic           miso
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, RESP} state_e;

  state_e         state_q, state_d;
  logic [DW-1:0]  div_q, div_d;
  logic [6:0]     bits_q, bits_d;
  logic [2:0]     sel_q, sel_d;
  logic [63:0]    tx_q, tx_d, rx_q, rx_d, rdata_q, rdata_d;
  logic           idle_q, idle_d, sck_q, sck_d, mosi_q, mosi_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [NSS-1:0] ss_q, ss_d;
`ifdef SPI_MASTER_CTRL_LSB_FIRST_EN
  logic [6:0]     len_q, len_d;
`endif
  logic [6:0]     len_c;
  logic           accept, phase_end, active, tx_bit;
  logic [63:0]    rx_shift;

  always_comb begin
    len_c     = (req_len > 7'd64) ? 7'd64 : req_len;
    accept    = req_valid && req_ready;
    phase_end = (div_q == DIV_LAST);
`ifdef SPI_MASTER_CTRL_LSB_FIRST_EN
    rx_shift  = {miso, rx_q[63:1]};
    len_d     = len_q;
`else
    rx_shift  = {rx_q[62:0], miso};
`endif
    state_d = state_q;
    div_d   = div_q;
    bits_d  = bits_q;
    sel_d   = sel_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;

    case (state_q)
      IDLE: if (accept) begin
        sel_d  = req_sel;
        bits_d = len_c;
        div_d  = '0;
        rx_d   = '0;
`ifdef SPI_MASTER_CTRL_LSB_FIRST_EN
        len_d  = len_c;
        tx_d   = req_wdata;
`else
        // Left-align so the first bit to send always sits in tx[63]
        tx_d   = req_wdata << (7'd64 - len_c);
`endif
        if (len_c == 7'd0) begin
          state_d = RESP;
          rdata_d = '0;
        end else begin
          state_d = SETUP;
        end
      end
      SETUP: if (phase_end) begin
        state_d = HIGH;
        div_d   = '0;
        rx_d    = rx_shift;
      end else begin
        div_d = div_q + 1'b1;
      end
      HIGH: if (phase_end) begin
        state_d = LOW;
        div_d   = '0;
        bits_d  = bits_q - 7'd1;
`ifdef SPI_MASTER_CTRL_LSB_FIRST_EN
        tx_d    = tx_q >> 1;
`else
        tx_d    = tx_q << 1;
`endif
      end else begin
        div_d = div_q + 1'b1;
      end
      LOW: if (phase_end) begin
        div_d = '0;
        if (bits_q == 7'd0) begin
          state_d = RESP;
`ifdef SPI_MASTER_CTRL_LSB_FIRST_EN
          rdata_d = rx_q >> (7'd64 - len_q);
`else
          rdata_d = rx_q;
`endif
        end else begin
          state_d = HIGH;
          rx_d    = rx_shift;
        end
      end else begin
        div_d = div_q + 1'b1;
      end
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they register in step with it
    active = (state_d == SETUP) || (state_d == HIGH) || (state_d == LOW);
`ifdef SPI_MASTER_CTRL_LSB_FIRST_EN
    tx_bit = tx_d[0];
`else
    tx_bit = tx_d[63];
`endif
    mosi_d      = (active && bits_d != 7'd0) ? tx_bit : 1'b1;
    sck_d       = (state_d == HIGH);
    idle_d      = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
    for (int unsigned i = 0; i < NSS; i++) begin
      ss_d[i] = !(active && (32'(sel_d) == i));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      div_q       <= '0;
      bits_q      <= '0;
      sel_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      rdata_q     <= '0;
      idle_q      <= 1'b1;
      sck_q       <= 1'b0;
      mosi_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      ss_q        <= '1;
`ifdef SPI_MASTER_CTRL_LSB_FIRST_EN
      len_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bits_q      <= bits_d;
      sel_q       <= sel_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      rdata_q     <= rdata_d;
      idle_q      <= idle_d;
      sck_q       <= sck_d;
      mosi_q      <= mosi_d;
      rsp_valid_q <= rsp_valid_d;
      ss_q        <= ss_d;
`ifdef SPI_MASTER_CTRL_LSB_FIRST_EN
      len_q       <= len_d;
`endif
    end
  end

  // Gating with reset lets req_ready rise in the very first cycle after release
  assign req_ready = idle_q && !reset;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign sck       = sck_q;
  assign ss        = ss_q;
  assign mosi      = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl (DIV=2, NSS=4); miso is a constant or looped back from mosi.
module tb_spi_master_ctrl;
  localparam int DIV = 2;
  localparam int NSS = 4;

  logic           clock = 1'b0;
  logic           reset, req_valid, req_ready, rsp_valid, rsp_ready;
  logic [6:0]     req_len;
  logic [2:0]     req_sel;
  logic [63:0]    req_wdata, rsp_rdata;
  logic           sck, mosi, miso, loopback, miso_val;
  logic [NSS-1:0] ss;

  int nvec = 0;
  int nmis = 0;

  always #5 clock = ~clock;
  assign miso = loopback ? mosi : miso_val;

  spi_master_ctrl #(.DIV(DIV), .NSS(NSS)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_len(req_len),
    .req_sel(req_sel), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .sck(sck), .ss(ss), .mosi(mosi), .miso(miso)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic handshake(input string tag);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check({tag, "_hs_ready"}, req_ready, 1'b1);
    check({tag, "_hs_valid"}, rsp_valid, 1'b0);
  endtask

  // Issues one request, then watches the bus until the response appears (left in RESP)
  task automatic txn(input string tag, input logic [6:0] len, input logic [2:0] sel,
                     input logic [63:0] wd, input logic [63:0] exp_rdata,
                     input int exp_cyc, input int exp_low, input int exp_pulses,
                     input logic [63:0] exp_mosi);
    int             cyc, low, pulses, idx;
    logic           prev_sck, bad;
    logic [NSS-1:0] prev_ss, exp_ss;
    logic [63:0]    mword;
    exp_ss = '1;
    if (int'(sel) < NSS) exp_ss[sel] = 1'b0;
    check({tag, "_ready_pre"}, req_ready, 1'b1);
    req_len = len; req_sel = sel; req_wdata = wd; req_valid = 1'b1;
    step();
    // Scrambled inputs must not disturb the latched request
    req_valid = 1'b0; req_len = 7'h7f; req_sel = ~sel; req_wdata = ~wd;
    low = 0; pulses = 0; idx = 0; bad = 1'b0; prev_sck = 1'b0; prev_ss = '1; mword = '0;
    for (cyc = 0; cyc < 600 && !rsp_valid; cyc++) begin
      if (ss != '1) begin
        low++;
        if (ss != exp_ss) bad = 1'b1;
      end
      if (ss != prev_ss && (sck || prev_sck)) bad = 1'b1;
      if (req_ready) bad = 1'b1;
      if (sck && !prev_sck) begin
        pulses++;
`ifdef SPI_MASTER_CTRL_LSB_FIRST_EN
        mword[idx] = mosi;
`else
        mword = {mword[62:0], mosi};
`endif
        idx++;
      end
      prev_sck = sck;
      prev_ss  = ss;
      step();
    end
    check({tag, "_timeout"}, !rsp_valid, 1'b0);
    check({tag, "_cycles"}, cyc, exp_cyc);
    check({tag, "_ss_low"}, low, exp_low);
    check({tag, "_pulses"}, pulses, exp_pulses);
    check({tag, "_mosi"}, mword, exp_mosi);
    check({tag, "_bus_ok"}, bad, 1'b0);
    check({tag, "_rsp_ss"}, ss, {NSS{1'b1}});
    check({tag, "_rsp_sck"}, sck, 1'b0);
    check({tag, "_rsp_mosi"}, mosi, 1'b1);
    check({tag, "_rsp_ready"}, req_ready, 1'b0);
    check({tag, "_rdata"}, rsp_rdata, exp_rdata);
  endtask

  initial begin
    int   pulses;
    logic prev_sck, seen_rsp;
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; loopback = 1'b0; miso_val = 1'b1;
    req_len = '0; req_sel = '0; req_wdata = '0;
    repeat (3) step();
    check("rst_ss", ss, {NSS{1'b1}});
    check("rst_sck", sck, 1'b0);
    check("rst_mosi", mosi, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_rdata", rsp_rdata, 64'h0);
    reset = 1'b0;
    #1;
    check("rst_release_ready", req_ready, 1'b1);
    step();

    txn("a5", 7'd8, 3'd0, 64'hA5, 64'hFF, 34, 34, 8, 64'hA5);
    handshake("a5");

    loopback = 1'b1;
    txn("loop64", 7'd64, 3'd1, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 258, 258, 64,
        64'h0123456789ABCDEF);
    handshake("loop64");
    txn("clamp", 7'd100, 3'd3, 64'hFEDCBA9876543210, 64'hFEDCBA9876543210, 258, 258, 64,
        64'hFEDCBA9876543210);
    handshake("clamp");
    loopback = 1'b0;

    txn("len0", 7'd0, 3'd2, 64'hFFFF, 64'h0, 0, 0, 0, 64'h0);
    handshake("len0");

    miso_val = 1'b0;
    txn("bp", 7'd4, 3'd1, 64'h9, 64'h0, 18, 18, 4, 64'h9);
    req_len = 7'd8; req_sel = 3'd0; req_wdata = 64'h55; req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_hold_valid", rsp_valid, 1'b1);
      check("bp_hold_rdata", rsp_rdata, 64'h0);
      check("bp_hold_ready", req_ready, 1'b0);
      check("bp_hold_ss", ss, {NSS{1'b1}});
    end
    req_valid = 1'b0;
    handshake("bp");
    miso_val = 1'b1;
    txn("bp_next", 7'd4, 3'd2, 64'h6, 64'hF, 18, 18, 4, 64'h6);
    handshake("bp_next");

    // Abort a 16-bit transfer once its third bit has been clocked
    req_len = 7'd16; req_sel = 3'd1; req_wdata = 64'hBEEF; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    pulses = 0; prev_sck = 1'b0;
    for (int i = 0; i < 200 && pulses < 3; i++) begin
      if (sck && !prev_sck) pulses++;
      prev_sck = sck;
      if (pulses < 3) step();
    end
    check("abort_reached", pulses, 3);
    check("abort_pre_ss", ss, 4'b1101);
    reset = 1'b1;
    step();
    check("abort_ss", ss, {NSS{1'b1}});
    check("abort_sck", sck, 1'b0);
    check("abort_rsp_valid", rsp_valid, 1'b0);
    check("abort_req_ready", req_ready, 1'b0);
    step();
    reset = 1'b0;
    #1;
    check("abort_release_ready", req_ready, 1'b1);
    seen_rsp = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (rsp_valid || ss != '1 || sck) seen_rsp = 1'b1;
    end
    check("abort_quiet", seen_rsp, 1'b0);

    txn("sel7", 7'd8, 3'd7, 64'h3C, 64'hFF, 34, 0, 8, 64'h3C);
    handshake("sel7");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
